// File: rtl/bitwise_gate_unit.sv
// Registered bitwise gate with an optional multi-beat accumulation mode.
// A valid/ready handshake sits on both sides; one result register feeds the consumer.
module bitwise_gate_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_all,
  output logic             y_any,
  output logic [CNT_W-1:0] beats
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_all_q, y_all_d;
  logic             y_any_q, y_any_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] res_new;
  logic [WIDTH-1:0] res_acc;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    unique case (sel)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~(x & z);
      3'd4: r = ~(x | z);
      3'd5: r = ~(x ^ z);
      3'd6: r = ~x;
      3'd7: r = x;
    endcase
    return r;
  endfunction

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Fresh operation uses the live op; accumulation folds a into acc with the latched op.
  assign res_new = gate_fn(op, a, b);
  assign res_acc = gate_fn(op_q, acc_q, a);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    y_d     = y_q;
    beats_d = beats_q;
    load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!acc_mode || last) begin
            load    = 1'b1;
            y_d     = res_new;
            beats_d = CntOne;
          end else begin
            op_d    = op;
            acc_d   = res_new;
            cnt_d   = CntOne;
            state_d = StAcc;
          end
        end
      end
      StAcc: begin
        if (accept) begin
          if (last) begin
            load    = 1'b1;
            y_d     = res_acc;
            beats_d = cnt_inc;
            state_d = StIdle;
          end else begin
            acc_d = res_acc;
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Flags follow the value entering y so they can never disagree with it.
    y_all_d = load ? (&y_d) : y_all_q;
    y_any_d = load ? (|y_d) : y_any_q;

    // A new load beats the consumer's take, giving one result per cycle.
    out_valid_d = out_valid_q;
    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      y_q         <= '0;
      y_all_q     <= 1'b0;
      y_any_q     <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      y_q         <= y_d;
      y_all_q     <= y_all_d;
      y_any_q     <= y_any_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign y_all     = y_all_q;
  assign y_any     = y_any_q;
  assign beats     = beats_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bitwise_gate_unit.sv
// Bench for bitwise_gate_unit: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_bitwise_gate_unit;

  localparam int W       = 8;
  localparam int CW      = 8;
  localparam int MaxBeats = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    op = '0;
  logic          acc_mode = 1'b0;
  logic          last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  y;
  logic          y_all;
  logic          y_any;
  logic [CW-1:0] beats;

  int total = 0;
  int bad   = 0;

  bitwise_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_mode  (acc_mode),
    .last      (last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_all     (y_all),
    .y_any     (y_any),
    .beats     (beats)
  );

  always #5 clk = ~clk;

  // Reference model: one pending result plus an open-sequence record.
  logic         m_valid;
  logic [W-1:0] m_y;
  int           m_beats;
  logic         m_in_seq;
  logic [2:0]   m_op;
  logic [W-1:0] m_acc;
  int           m_cnt;

  function automatic logic [W-1:0] fref(input logic [2:0] s, input logic [W-1:0] x,
                                        input logic [W-1:0] z);
    case (s)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_y = '0; m_beats = 0;
    m_in_seq = 1'b0; m_op = '0; m_acc = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic         taken;
    logic         ld;
    logic [W-1:0] r;
    int           n;
    taken = in_valid && (!m_valid || out_ready);
    ld = 1'b0;
    if (taken) begin
      if (!m_in_seq) begin
        if (!acc_mode || last) begin
          ld = 1'b1; m_y = fref(op, a, b); m_beats = 1;
        end else begin
          m_in_seq = 1'b1; m_op = op; m_acc = fref(op, a, b); m_cnt = 1;
        end
      end else begin
        r = fref(m_op, m_acc, a);
        n = (m_cnt + 1 > MaxBeats) ? MaxBeats : m_cnt + 1;
        if (last) begin
          ld = 1'b1; m_y = r; m_beats = n; m_in_seq = 1'b0;
        end else begin
          m_acc = r; m_cnt = n;
        end
      end
    end
    if (ld) m_valid = 1'b1;
    else if (out_ready) m_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || out_ready));
    chk({tag, ".y"}, 64'(y), 64'(m_y));
    chk({tag, ".y_all"}, 64'(y_all), 64'(&m_y));
    chk({tag, ".y_any"}, 64'(y_any), 64'(|m_y));
    chk({tag, ".beats"}, 64'(beats), 64'(m_beats));
  endtask

  // One clock: model sees the inputs stable at the edge, return at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic am, input logic ls);
    in_valid = v; op = o; a = aa; b = bb; acc_mode = am; last = ls;
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         all;
    logic         any;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [W-1:0] exp_y;
    logic [W-1:0] sat_a;

    vecs[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b1};
    vecs[1] = '{3'd1, 8'hF0, 8'h0F, 8'hFF, 1'b1, 1'b1};
    vecs[2] = '{3'd2, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1};
    vecs[5] = '{3'd5, 8'hA5, 8'hA5, 8'hFF, 1'b1, 1'b1};
    vecs[6] = '{3'd6, 8'h00, 8'h12, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{3'd7, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[8] = '{3'd6, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b1};
    vecs[9] = '{3'd1, 8'h12, 8'h34, 8'h36, 1'b0, 1'b1};

    model_reset();
    #1;
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.y", 64'(y), 64'd0);
    chk("reset.beats", 64'(beats), 64'd0);
    chk("reset.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset.in_ready", 64'(in_ready), 64'd1);

    // Single-beat vector table; last is a don't-care when acc_mode=0.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'($urandom_range(0, 1)));
      cycle();
      in_valid = 1'b0;
      chk($sformatf("vec%0d.y", i), 64'(y), 64'(vecs[i].y));
      chk($sformatf("vec%0d.y_all", i), 64'(y_all), 64'(vecs[i].all));
      chk($sformatf("vec%0d.y_any", i), 64'(y_any), 64'(vecs[i].any));
      chk($sformatf("vec%0d.beats", i), 64'(beats), 64'd1);
      chk($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
    end
    cycle();
    chk("drain.out_valid", 64'(out_valid), 64'd0);

    // Backpressure: result held, new beat stalled until the consumer takes it.
    drive(1'b1, 3'd1, 8'h0F, 8'hF0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd0, 8'h3C, 8'h0F, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("stall%0d.y", i), 64'(y), 64'hFF);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    chk("unstall.y", 64'(y), 64'h0C);
    chk("unstall.out_valid", 64'(out_valid), 64'd1);
    cycle();

    // Three-beat XOR accumulation, one output pulse.
    drive(1'b1, 3'd2, 8'h0F, 8'hFF, 1'b1, 1'b0);
    cycle();
    chk("acc1.out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd0, 8'h33, 8'h00, 1'b0, 1'b0);
    cycle();
    chk("acc2.out_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd5, 8'h55, 8'h77, 1'b1, 1'b1);
    cycle();
    in_valid = 1'b0;
    exp_y = ((8'h0F ^ 8'hFF) ^ 8'h33) ^ 8'h55;
    chk("acc3.y", 64'(y), 64'(exp_y));
    chk("acc3.beats", 64'(beats), 64'd3);
    chk("acc3.out_valid", 64'(out_valid), 64'd1);
    cycle();
    chk("acc3.pulse_end", 64'(out_valid), 64'd0);

    // Asynchronous reset in the middle of a sequence.
    drive(1'b1, 3'd7, 8'h5A, 8'h00, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd1, 8'h01, 8'h02, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 3'd1, 8'h04, 8'h00, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pre_rst.y", 64'(y), 64'h5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst.out_valid", 64'(out_valid), 64'd0);
    chk("async_rst.y", 64'(y), 64'd0);
    chk("async_rst.beats", 64'(beats), 64'd0);
    chk("async_rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 8'hAA, 8'hFF, 1'b0, 1'b0);
    cycle();
    in_valid = 1'b0;
    chk("after_rst.y", 64'(y), 64'hAA);
    chk("after_rst.beats", 64'(beats), 64'd1);
    cycle();

    // Full throughput: a new result every cycle.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'b0, 1'b0);
      #1;
      chk($sformatf("tput%0d.in_ready", i), 64'(in_ready), 64'd1);
      exp_y = fref(op, a, b);
      cycle();
      chk($sformatf("tput%0d.out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tput%0d.y", i), 64'(y), 64'(exp_y));
    end
    in_valid = 1'b0;
    cycle();

    // Beat counter saturation over a long pass-through sequence.
    sat_a = W'($urandom);
    drive(1'b1, 3'd7, sat_a, 8'h00, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 3'd0, W'($urandom), 8'h00, 1'b0, 1'b0);
      cycle();
    end
    last = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("sat.beats", 64'(beats), 64'(MaxBeats));
    chk("sat.y", 64'(y), 64'(sat_a));
    chk("sat.out_valid", 64'(out_valid), 64'd1);
    cycle();

    // Randomized traffic with random backpressure against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), W'($urandom),
            W'($urandom), 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 3));
      out_ready = 1'($urandom_range(0, 9) < 7);
      #1;
      check_all($sformatf("rand%0d", i));
      cycle();
    end
    in_valid = 1'b0;
    #1;
    check_all("rand_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
